seg7_scan: RTL and testbench

- Board-level display stage that sits directly downstream of the SoC GPIO output in the Nexys2 top.
- Consumes a 16-bit value, plus decimal-point and digit-enable masks, and drives the board's 4-digit common-anode seven-segment display by time multiplexing.
- Double-buffers its input: a new value is committed only at a frame boundary, so a refresh never shows a half-old, half-new value ("tearing").

---
 rtl/seg7_pkg.sv | 73 +++++++
 rtl/seg7_hexdec.sv | 21 ++
 rtl/seg7_scan.sv | 198 +++++++++++++++++++
 tb/tb_seg7_scan.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_pkg                                                        |
// | Purpose  : Shared constants, types and the hex-to-segment decode used by  |
// |            the seven-segment scan stage.                                   |
// | Contents : DIGITS, active-low segment codes (SEG_OFF, SEG_0..SEG_F),       |
// |            scan_state_e {BLANK, SHOW}, disp_cfg_t (one display snapshot),  |
// |            hex2seg() nibble decoder.                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  localparam int DIGITS = 4;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low (0 = lit).
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;

  // Per-slot scan phase: anodes dark first, then the digit is driven.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Everything captured by one update strobe; held as a unit so the pending
  // and display copies can never disagree field-by-field.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lzb;
  } disp_cfg_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hexdec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_hexdec                                                     |
// | Purpose  : Purely combinational hex nibble to seven-segment decoder.       |
// | Ports    : nib_i [3:0]  hex nibble to display                              |
// |            seg_o [6:0]  {g,f,e,d,c,b,a}, active-low                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex2seg(nib_i);
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan                                                       |
// | Purpose  : Time-multiplexed driver for a 4-digit common-anode display with |
// |            a frame-synchronous double buffer (no tearing), per-digit       |
// |            enable, decimal points and leading-zero blanking.               |
// | Params   : REFRESH_DIV  clock cycles per digit slot (4 .. 2**20)           |
// |            BLANK_CYCLES dark cycles at the start of each slot              |
// |                         (1 .. REFRESH_DIV-1)                               |
// | Ports    : clk_i        system clock                                       |
// |            rst_i        synchronous reset, active-high                     |
// |            data_i[15:0] hex value, nibble k shown on digit k               |
// |            dp_i[3:0]    decimal point per digit, 1 = lit                   |
// |            en_i[3:0]    digit enable, 1 = digit may light                  |
// |            lzb_i        leading-zero blanking enable                       |
// |            upd_i        one-cycle strobe capturing data/dp/en/lzb          |
// |            an_o[3:0]    anodes, active-low                                 |
// |            seg_o[6:0]   segments {g,f,e,d,c,b,a}, active-low               |
// |            dp_o         decimal point, active-low                          |
// |            frame_o      one-cycle pulse per commit point                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] data_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  en_i,
  input  logic        lzb_i,
  input  logic        upd_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int            CW           = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] C_CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);

  // --------------------------------------------------------------------------
  // Scan position: slot counter runs 0..REFRESH_DIV-1 across the whole slot;
  // the FSM tracks which phase of the slot that count falls in.
  // --------------------------------------------------------------------------
  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    dig_q,   dig_d;
  logic          slot_end_w;

  assign slot_end_w = (cnt_q == C_CNT_LAST);

  always_comb begin
    cnt_d = slot_end_w ? '0 : (cnt_q + C_CNT_ONE);
    dig_d = slot_end_w ? (dig_q + 2'd1) : dig_q;
  end

  // FSM process 1: state register (with counter and digit index).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end

  // FSM process 2: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == C_BLANK_LAST) state_d = SHOW;
      SHOW:    if (slot_end_w)            state_d = BLANK;
      default:                            state_d = BLANK;
    endcase
  end

  // --------------------------------------------------------------------------
  // Double buffer. The only cycle in which the display copy may change is the
  // first cycle of digit 0's blank phase, so a frame is always drawn from one
  // consistent snapshot.
  // --------------------------------------------------------------------------
  disp_cfg_t disp_q,  disp_d;
  disp_cfg_t pend_q,  pend_d;
  logic      pflag_q, pflag_d;
  disp_cfg_t in_cfg_w;
  logic      commit_w;

  assign in_cfg_w = '{data: data_i, dp: dp_i, en: en_i, lzb: lzb_i};
  assign commit_w = (state_q == BLANK) && (dig_q == 2'd0) && (cnt_q == '0);

  always_comb begin
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    if (commit_w) begin
      // A strobe landing on the commit cycle is newer than anything pending,
      // so it goes straight to the display and the pending copy is dropped.
      if (upd_i) begin
        disp_d = in_cfg_w;
      end else if (pflag_q) begin
        disp_d = pend_q;
      end
      pflag_d = 1'b0;
    end else if (upd_i) begin
      pend_d  = in_cfg_w;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
    end else begin
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Digit selection and suppression
  // --------------------------------------------------------------------------
  logic [3:0]  nib_w;
  logic [6:0]  seg_dec_w;
  logic [15:0] upper_w;
  logic        suppress_w;

  assign nib_w   = disp_q.data[{dig_q, 2'b00} +: 4];
  // This nibble and every higher one, shifted down; zero means "leading zero".
  assign upper_w = disp_q.data >> {dig_q, 2'b00};

  // Digit 0 is exempt from blanking so a value of zero still shows "0".
  assign suppress_w = ~disp_q.en[dig_q]
                    | (disp_q.lzb & (dig_q != 2'd0) & (upper_w == 16'h0000));

  seg7_hexdec u_hexdec (
    .nib_i (nib_w),
    .seg_o (seg_dec_w)
  );

  // FSM process 3: output logic, registered below so every output is
  // glitch-free and lags the scan state by exactly one cycle.
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == SHOW) begin
      // Segments are decoded even for a suppressed digit; the dark anode
      // alone keeps it unlit while it still uses up its slot.
      seg_d = seg_dec_w;
      dp_d  = ~disp_q.dp[dig_q];
      if (!suppress_w) begin
        an_d = ~(4'b0001 << dig_q);
      end
    end
  end

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;
  logic       frame_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_q    <= 4'hF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= commit_w;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg7_scan                                                    |
// | Purpose  : Self-checking bench for seg7_scan (REFRESH_DIV=8,               |
// |            BLANK_CYCLES=2): per-cycle reference model, table of display   |
// |            snapshots, hand-written commit/reset corner sequences and a     |
// |            randomized update phase.                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seg7_scan;

  localparam int R  = 8;
  localparam int B  = 2;
  localparam int FR = 4 * R;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic [3:0]  en_i;
  logic        lzb_i;
  logic        upd_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  always #5 clk = ~clk;

  seg7_scan #(
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .dp_i    (dp_i),
    .en_i    (en_i),
    .lzb_i   (lzb_i),
    .upd_i   (upd_i),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o),
    .frame_o (frame_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Time is a plain cycle index since reset; slot/phase come from arithmetic.
  logic [6:0]  hex_tbl [16];
  logic [15:0] m_data, p_data;
  logic [3:0]  m_dp, m_en, p_dp, p_en;
  logic        m_lzb, p_lzb, m_pflag;
  int          cyc;

  function automatic logic [11:0] expect_disp(input int c);
    int          p, d, off;
    logic [15:0] sh;
    logic [3:0]  one, an;
    logic        sup;
    p   = c % FR;
    d   = p / R;
    off = p % R;
    if (off < B) return {4'hF, 7'h7F, 1'b1};
    sh  = m_data >> (4 * d);
    sup = !m_en[d] || (m_lzb && d != 0 && sh == 16'h0000);
    one = 4'b0001;
    an  = sup ? 4'hF : ~(one << d);
    return {an, hex_tbl[sh[3:0]], ~m_dp[d]};
  endfunction

  task automatic model_clear();
    m_data = '0; m_dp = '0; m_en = '0; m_lzb = 1'b0;
    p_data = '0; p_dp = '0; p_en = '0; p_lzb = 1'b0;
    m_pflag = 1'b0;
    cyc = 0;
  endtask

  // One clock: advance model with the inputs present at the edge, compare.
  task automatic tick();
    logic [11:0] exp_o;
    logic        exp_f;
    @(posedge clk);
    if (rst_i) begin
      exp_o = {4'hF, 7'h7F, 1'b1};
      exp_f = 1'b0;
      model_clear();
    end else begin
      exp_o = expect_disp(cyc);
      exp_f = (cyc % FR == 0);
      if (cyc % FR == 0) begin
        if (upd_i) begin
          m_data = data_i; m_dp = dp_i; m_en = en_i; m_lzb = lzb_i;
        end else if (m_pflag) begin
          m_data = p_data; m_dp = p_dp; m_en = p_en; m_lzb = p_lzb;
        end
        m_pflag = 1'b0;
      end else if (upd_i) begin
        p_data = data_i; p_dp = dp_i; p_en = en_i; p_lzb = lzb_i;
        m_pflag = 1'b1;
      end
      cyc++;
    end
    #1;
    vectors++;
    if ({an_o, seg_o, dp_o} !== exp_o || frame_o !== exp_f) begin
      miscompares++;
      $display("FAIL model cyc=%0d: an/seg/dp/frame got %h/%h/%b/%b expected %h/%h/%b/%b",
               cyc, an_o, seg_o, dp_o, frame_o, exp_o[11:8], exp_o[7:1], exp_o[0], exp_f);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs until frame_o is seen high (bounded); leaves time at that cycle.
  task automatic wait_frame();
    int n;
    n = 0;
    tick();
    while (frame_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (frame_o !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_frame: frame_o not seen within 40 cycles, got %b expected 1", frame_o);
    end
  endtask

  task automatic pulse_upd(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                           input logic lz);
    data_i = d; dp_i = dp; en_i = en; lzb_i = lz; upd_i = 1'b1;
    tick();
    upd_i  = 1'b0;
    data_i = 16'($urandom);  // must be ignored without a strobe
    dp_i   = 4'($urandom);
  endtask

  task automatic align(input int phase);
    while (cyc % FR != phase) tick();
  endtask

  // ---------------- snapshot table ----------------
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lzb;
    logic [15:0] an_exp;   // digit k at [4k+:4]
    logic [27:0] seg_exp;  // digit k at [7k+:7]
    logic [3:0]  dpo_exp;  // digit k at [k]
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] mask;
    int          frames;
    logic        saw_f;

    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    tbl[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    tbl[1] = '{16'h00A0, 4'h0, 4'hF, 1'b1, 16'hFFDE, {7'h40, 7'h40, 7'h08, 7'h40}, 4'hF};
    tbl[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, 16'hFFFE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
    tbl[3] = '{16'h0000, 4'h0, 4'hE, 1'b1, 16'hFFFF, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
    tbl[4] = '{16'h8888, 4'h0, 4'hF, 1'b0, 16'h7BDE, {7'h00, 7'h00, 7'h00, 7'h00}, 4'hF};
    tbl[5] = '{16'hC0DE, 4'h8, 4'hB, 1'b0, 16'h7FDE, {7'h46, 7'h40, 7'h21, 7'h06}, 4'h7};
    tbl[6] = '{16'h1000, 4'h6, 4'hF, 1'b1, 16'h7BDE, {7'h79, 7'h40, 7'h40, 7'h40}, 4'h9};
    tbl[7] = '{16'h0050, 4'hF, 4'hF, 1'b1, 16'hFFDE, {7'h40, 7'h40, 7'h12, 7'h40}, 4'h0};

    rst_i = 1'b1; upd_i = 1'b0; data_i = '0; dp_i = '0; en_i = '0; lzb_i = 1'b0;
    model_clear();
    ticks(3);
    check("reset_outputs", {20'h0, an_o, seg_o, dp_o}, {20'h0, 4'hF, 7'h7F, 1'b1});
    check("reset_frame", {31'h0, frame_o}, 32'h0);
    rst_i = 1'b0;

    // Table: commit each snapshot, then inspect the middle of every lit slot.
    for (int i = 0; i < 8; i++) begin
      ticks($urandom_range(0, 20));
      pulse_upd(tbl[i].data, tbl[i].dp, tbl[i].en, tbl[i].lzb);
      wait_frame();
      for (int k = 0; k < 4; k++) begin
        ticks(k == 0 ? 4 : 8);
        check($sformatf("tbl%0d_an_d%0d", i, k), {28'h0, an_o}, {28'h0, tbl[i].an_exp[4*k +: 4]});
        check($sformatf("tbl%0d_seg_d%0d", i, k), {25'h0, seg_o}, {25'h0, tbl[i].seg_exp[7*k +: 7]});
        check($sformatf("tbl%0d_dp_d%0d", i, k), {31'h0, dp_o}, {31'h0, tbl[i].dpo_exp[k]});
      end
    end

    // Last strobe before the commit wins; FFFF must never reach the display.
    align(10);
    pulse_upd(16'hFFFF, 4'h0, 4'hF, 1'b0);
    align(25);
    pulse_upd(16'h8888, 4'h0, 4'hF, 1'b0);
    frames = 0;
    saw_f  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (frame_o === 1'b1) frames++;
      if (an_o !== 4'hF && seg_o === 7'h0E) saw_f = 1'b1;
    end
    check("last_wins_frames_in_64", frames, 2);
    check("last_wins_no_FFFF", {31'h0, saw_f}, 32'h0);

    // Strobe exactly on the commit cycle bypasses into the same frame.
    align(0);
    data_i = 16'h5555; dp_i = 4'b0101; en_i = 4'hF; lzb_i = 1'b0; upd_i = 1'b1;
    tick();
    upd_i = 1'b0;
    check("bypass_frame", {31'h0, frame_o}, 32'h1);
    ticks(4);
    check("bypass_d0_seg", {25'h0, seg_o}, {25'h0, 7'h12});
    check("bypass_d0_an", {28'h0, an_o}, {28'h0, 4'hE});
    check("bypass_d0_dp", {31'h0, dp_o}, 32'h0);
    ticks(8);
    check("bypass_d1_dp", {31'h0, dp_o}, 32'h1);
    ticks(8);
    check("bypass_d2_dp", {31'h0, dp_o}, 32'h0);

    // Reset in the middle of digit 2's lit phase.
    align(2 * R + 3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midreset_outputs", {20'h0, an_o, seg_o, dp_o}, {20'h0, 4'hF, 7'h7F, 1'b1});
    tick();
    check("midreset_first_commit", {31'h0, frame_o}, 32'h1);
    ticks(4);
    check("midreset_d0_an", {28'h0, an_o}, {28'h0, 4'hF});
    check("midreset_d0_seg", {25'h0, seg_o}, {25'h0, 7'h40});

    // Randomized updates against the model.
    for (int i = 0; i < 1500; i++) begin
      data_i = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        mask   = 16'hFFFF >> (4 * $urandom_range(1, 4));
        data_i = data_i & mask;
      end
      dp_i  = 4'($urandom);
      en_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      lzb_i = 1'($urandom);
      upd_i = ($urandom_range(0, 19) == 0);
      tick();
    end
    upd_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
